// File: rtl/bidir_bus_port.sv
// Half-duplex initiator for a shared bidirectional data bus: turns valid/ready
// requests into strobed read/write bus cycles with enforced turnaround gaps.
// Optional bus parity is built when BIDIR_PARITY_EN is defined.
module bidir_bus_port #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned SAMPLE_DLY = 2,
  parameter int unsigned TURN_CYC   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  inout  wire  [DATA_W-1:0] bus_data,
`ifdef BIDIR_PARITY_EN
  inout  wire               bus_par,
  output logic              rsp_perr,
`endif
  output logic              bus_oe_n,
  output logic              bus_dir,
  output logic              bus_strobe
);

  localparam int unsigned MAX_CYC = (SAMPLE_DLY > TURN_CYC) ? SAMPLE_DLY : TURN_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_DRIVE,
    S_WR_HOLD,
    S_RD_STROBE,
    S_RD_WAIT,
    S_TURN
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_wdata;
  logic              r_oe_n;
  logic              r_dir;
  logic              r_strobe;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rdata;
  logic              w_capture;
  logic              w_accept;
  logic              w_oe_n;
  logic              w_dir;
  logic              w_strobe;

  assign w_accept = (r_state == S_IDLE) && req_valid;

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    case (r_state)
      S_IDLE:      if (req_valid) w_next = req_write ? S_WR_DRIVE : S_RD_STROBE;
      S_WR_DRIVE:  w_next = S_WR_HOLD;
      S_WR_HOLD:   w_next = S_TURN;
      S_RD_STROBE: w_next = S_RD_WAIT;
      S_RD_WAIT: begin
        if (r_cnt == CNT_W'(SAMPLE_DLY - 1)) begin
          w_next    = S_TURN;
          w_capture = 1'b1;
        end
      end
      S_TURN:      if (r_cnt == CNT_W'(TURN_CYC - 1)) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // Bus controls are decoded from the next state so they are registered
  // alongside the state they belong to.
  always_comb begin
    w_oe_n   = 1'b1;
    w_dir    = 1'b0;
    w_strobe = 1'b0;
    case (w_next)
      S_WR_DRIVE: begin
        w_oe_n   = 1'b0;
        w_dir    = 1'b1;
        w_strobe = 1'b1;
      end
      S_WR_HOLD: begin
        w_oe_n = 1'b0;
        w_dir  = 1'b1;
      end
      S_RD_STROBE: w_strobe = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_wdata     <= '0;
      r_oe_n      <= 1'b1;
      r_dir       <= 1'b0;
      r_strobe    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_state     <= w_next;
      r_oe_n      <= w_oe_n;
      r_dir       <= w_dir;
      r_strobe    <= w_strobe;
      r_rsp_valid <= w_capture;
      if (w_next != r_state) begin
        r_cnt <= '0;
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_accept) r_wdata <= req_wdata;
      if (w_capture) r_rdata <= bus_data;
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rdata;
  assign bus_oe_n   = r_oe_n;
  assign bus_dir    = r_dir;
  assign bus_strobe = r_strobe;
  assign bus_data   = r_oe_n ? 'z : r_wdata;

`ifdef BIDIR_PARITY_EN
  logic r_wpar;
  logic r_perr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wpar <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      if (w_accept) r_wpar <= ^req_wdata;
      r_perr <= w_capture && (^{bus_data, bus_par});
    end
  end

  assign bus_par  = r_oe_n ? 1'bz : r_wpar;
  assign rsp_perr = r_perr;
`endif

endmodule

// File: tb/tb_bidir_bus_port.sv
// Directed bench for bidir_bus_port with a peer bus model and a read-response
// scoreboard; covers parity too when BIDIR_PARITY_EN is defined.
module tb_bidir_bus_port;

  localparam int unsigned DW   = 8;
  localparam int unsigned SDLY = 2;
  localparam int unsigned TCYC = 1;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          perr;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          bus_oe_n;
  logic          bus_dir;
  logic          bus_strobe;
  wire  [DW-1:0] bus_data;

  logic          peer_oe = 1'b0;
  logic [DW-1:0] peer_data = '0;
  logic [DW-1:0] peer_val = '0;
  logic          peer_pval = 1'b0;
  int unsigned   peer_cnt = 0;

  int            errors = 0;
  int            checks = 0;
  int            rsp_seen = 0;
  exp_t          q[$];
  logic [DW-1:0] last_rdata = '0;

  assign bus_data = peer_oe ? peer_data : 'z;

`ifdef BIDIR_PARITY_EN
  wire  bus_par;
  logic rsp_perr;
  logic peer_par = 1'b0;
  assign bus_par = peer_oe ? peer_par : 1'bz;
`endif

  bidir_bus_port #(
    .DATA_W    (DW),
    .SAMPLE_DLY(SDLY),
    .TURN_CYC  (TCYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .bus_data  (bus_data),
`ifdef BIDIR_PARITY_EN
    .bus_par   (bus_par),
    .rsp_perr  (rsp_perr),
`endif
    .bus_oe_n  (bus_oe_n),
    .bus_dir   (bus_dir),
    .bus_strobe(bus_strobe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) until req_ready, then lets the acceptance edge pass.
  task automatic accept();
    int n = 0;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    check("accept_timeout", n < 20, 1);
    step();
  endtask

  // Peer: on a read strobe, drives its value until the turnaround cycle.
  always @(negedge clk) begin
    if (bus_strobe && !bus_dir) begin
      peer_oe   <= 1'b1;
      peer_data <= peer_val;
`ifdef BIDIR_PARITY_EN
      peer_par  <= peer_pval;
`endif
      peer_cnt  <= SDLY + 1;
    end else if (peer_cnt > 1) begin
      peer_cnt <= peer_cnt - 1;
    end else begin
      peer_cnt <= 0;
      peer_oe  <= 1'b0;
    end
  end

  // Monitor: contention, response scoreboard and rsp_rdata hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_rdata = '0;
    end else begin
      check("contention", {31'd0, peer_oe && !bus_oe_n}, 0);
      if (rsp_valid) begin
        if (q.size() == 0) begin
          check("rsp_spurious", {31'd0, rsp_valid}, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          rsp_seen++;
          check("rsp_rdata", rsp_rdata, e.d);
`ifdef BIDIR_PARITY_EN
          check("rsp_perr", rsp_perr, e.perr);
`endif
          last_rdata = e.d;
        end
      end else begin
        check("rdata_hold", rsp_rdata, last_rdata);
`ifdef BIDIR_PARITY_EN
        check("perr_idle", rsp_perr, 0);
`endif
      end
    end
  end

  // Called in the cycle after a read acceptance edge.
  task automatic read_tail(input string tag);
    check({tag, "_strobe"}, bus_strobe, 1);
    check({tag, "_dir"}, bus_dir, 0);
    check({tag, "_oe_n0"}, bus_oe_n, 1);
    check({tag, "_busy"}, req_ready, 0);
    step();
    check({tag, "_oe_n1"}, bus_oe_n, 1);
    check({tag, "_rv1"}, rsp_valid, 0);
    step();
    check({tag, "_rv2"}, rsp_valid, 0);
    step();
    check({tag, "_rv3"}, rsp_valid, 1);
    check({tag, "_oe_n3"}, bus_oe_n, 1);
    step();
    check({tag, "_rv4"}, rsp_valid, 0);
    check({tag, "_ready"}, req_ready, 1);
  endtask

  task automatic do_read(input string tag, input logic [DW-1:0] v, input logic p);
    exp_t e;
    peer_val  = v;
    peer_pval = p;
    e.d    = v;
    e.perr = (^v) ^ p;
    q.push_back(e);
    req_valid = 1'b1;
    req_write = 1'b0;
    accept();
    req_valid = 1'b0;
    read_tail(tag);
  endtask

  initial begin
    #10000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    // Reset
    repeat (2) @(negedge clk);
    check("rst_oe_n", bus_oe_n, 1);
    check("rst_strobe", bus_strobe, 0);
    check("rst_dir", bus_dir, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    step();
    rst_n = 1'b1;
    step();
    check("rst_ready", req_ready, 1);

    // Single write of A5
    req_valid = 1'b1;
    req_write = 1'b1;
    req_wdata = 8'hA5;
    accept();
    req_valid = 1'b0;
    req_wdata = 8'h00;
    check("wr_strobe", bus_strobe, 1);
    check("wr_dir", bus_dir, 1);
    check("wr_oe_n", bus_oe_n, 0);
    check("wr_data", bus_data, 8'hA5);
`ifdef BIDIR_PARITY_EN
    check("wr_par", bus_par, 0);
`endif
    check("wr_busy", req_ready, 0);
    step();
    check("wr_hold_strobe", bus_strobe, 0);
    check("wr_hold_oe_n", bus_oe_n, 0);
    check("wr_hold_data", bus_data, 8'hA5);
    step();
    check("wr_turn_oe_n", bus_oe_n, 1);
    check("wr_turn_busy", req_ready, 0);
    step();
    check("wr_ready", req_ready, 1);
    check("wr_no_rsp", rsp_valid, 0);

    // Single read of 3C
    do_read("rd3c", 8'h3C, 1'b0);
    step();
    check("rd3c_hold", rsp_rdata, 8'h3C);

    // Write then read with req_valid held continuously
    peer_val  = 8'hC3;
    peer_pval = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_wdata = 8'h5A;
    accept();
    req_write = 1'b0;
    req_wdata = 8'h00;
    check("wb_strobe", bus_strobe, 1);
    check("wb_data", bus_data, 8'h5A);
`ifdef BIDIR_PARITY_EN
    check("wb_par", bus_par, 0);
`endif
    check("wb_busy1", req_ready, 0);
    step();
    check("wb_busy2", req_ready, 0);
    check("wb_oe_hold", bus_oe_n, 0);
    step();
    check("wb_busy3", req_ready, 0);
    check("wb_turn_oe_n", bus_oe_n, 1);
    check("wb_turn_strobe", bus_strobe, 0);
    step();
    check("wb_idle_ready", req_ready, 1);
    check("wb_idle_strobe", bus_strobe, 0);
    e.d    = 8'hC3;
    e.perr = 1'b0;
    q.push_back(e);
    step();
    req_valid = 1'b0;
    read_tail("wb_rd");

    // Reset during RD_WAIT aborts the read
    peer_val  = 8'h77;
    req_valid = 1'b1;
    req_write = 1'b0;
    accept();
    req_valid = 1'b0;
    check("ab_strobe", bus_strobe, 1);
    step();
    rst_n = 1'b0;
    #1;
    check("ab_oe_n", bus_oe_n, 1);
    check("ab_rsp_valid", rsp_valid, 0);
    check("ab_strobe_clr", bus_strobe, 0);
    check("ab_rdata", rsp_rdata, 0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    check("ab_ready", req_ready, 1);
    do_read("rd96", 8'h96, 1'b0);

`ifdef BIDIR_PARITY_EN
    do_read("par_bad", 8'h01, 1'b0);
    do_read("par_good", 8'h01, 1'b1);
    do_read("par_ff", 8'hFF, 1'b0);
`endif

    repeat (3) step();
    check("q_empty", q.size(), 0);
`ifdef BIDIR_PARITY_EN
    check("rsp_count", rsp_seen, 6);
`else
    check("rsp_count", rsp_seen, 3);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
